// File: rtl/pipe_ctrl.sv
// Pipeline hazard / divider-wait / flush controller producing per-stage stall and flush.
// Optional stall statistics counter enabled by defining PIPE_CTRL_STAT_EN.
module pipe_ctrl #(
  parameter int unsigned DIV_MAX = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        div_start,
  input  logic        div_done,
  input  logic        excp_flush,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        div_busy,
  output logic        div_cancel,
  output logic        div_timeout,
  output logic [31:0] stall_cycles
);

  localparam int unsigned WCNT_W  = 6;
  localparam int unsigned STALL_W = 6;
  localparam logic [WCNT_W-1:0]  WCNT_LAST   = WCNT_W'(DIV_MAX - 1);
  localparam logic [STALL_W-1:0] STALL_NONE  = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_TO_ID = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_TO_EX = 6'b001111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WCNT_W-1:0]   wcnt;
  logic [WCNT_W-1:0]   wcnt_nxt;
  logic                timeout_set;

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wcnt        <= '0;
      div_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (timeout_set) begin
        div_timeout <= 1'b1;
      end
    end
  end

  // Next-state and stage-control decode
  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    timeout_set = 1'b0;
    stall       = STALL_NONE;
    flush       = 1'b0;
    div_cancel  = 1'b0;
    div_busy    = 1'b0;

    case (state)
      IDLE: begin
        if (stallreq_ex) begin
          stall = STALL_TO_EX;
        end else if (stallreq_id) begin
          stall = STALL_TO_ID;
        end
        if (excp_flush) begin
          state_nxt = FLUSH;
        end else if (div_start) begin
          state_nxt = DIV_WAIT;
          wcnt_nxt  = '0;
        end
      end

      DIV_WAIT: begin
        div_busy = 1'b1;
        // Release the freeze on the done cycle so EX/MEM captures the quotient
        stall    = div_done ? STALL_NONE : STALL_TO_EX;
        wcnt_nxt = wcnt + WCNT_W'(1);
        if (excp_flush) begin
          state_nxt = FLUSH;
        end else if (div_done) begin
          state_nxt = IDLE;
        end else if (wcnt == WCNT_LAST) begin
          timeout_set = 1'b1;
          state_nxt   = FLUSH;
        end
      end

      FLUSH: begin
        flush      = 1'b1;
        div_cancel = 1'b1;
        state_nxt  = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Hold every stage quiet while reset is asserted
    if (!rst) begin
      stall = STALL_NONE;
    end
  end

`ifdef PIPE_CTRL_STAT_EN
  logic [31:0] stat_cnt;

  // Saturating count of cycles with any stage stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_cnt <= '0;
    end else if ((stall != STALL_NONE) && (stat_cnt != 32'hFFFF_FFFF)) begin
      stat_cnt <= stat_cnt + 32'd1;
    end
  end

  assign stall_cycles = stat_cnt;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_pipe_ctrl;

  localparam int unsigned DIV_MAX = 40;
  localparam int unsigned EXP_W   = 42;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        div_start = 1'b0;
  logic        div_done = 1'b0;
  logic        excp_flush = 1'b0;
  logic [5:0]  stall;
  logic        flush;
  logic        div_busy;
  logic        div_cancel;
  logic        div_timeout;
  logic [31:0] stall_cycles;

  pipe_ctrl #(.DIV_MAX(DIV_MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .div_start    (div_start),
    .div_done     (div_done),
    .excp_flush   (excp_flush),
    .stall        (stall),
    .flush        (flush),
    .div_busy     (div_busy),
    .div_cancel   (div_cancel),
    .div_timeout  (div_timeout),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle_no = 0;

  logic [EXP_W-1:0] exp_q[$];

  // Behavioural model: is a divide outstanding, how long has it run, is a flush cycle due
  bit          m_dividing   = 1'b0;
  bit          m_flushing   = 1'b0;
  int unsigned m_elapsed    = 0;
  bit          m_timeout    = 1'b0;
  logic [31:0] m_stat       = '0;
  logic [5:0]  m_stall_prev = '0;

  function automatic void model_reset();
    m_dividing   = 1'b0;
    m_flushing   = 1'b0;
    m_elapsed    = 0;
    m_timeout    = 1'b0;
    m_stat       = '0;
    m_stall_prev = '0;
  endfunction

  // Advance the model across a rising edge using the inputs held during the cycle
  function automatic void model_step();
    if (!rst) begin
      model_reset();
      return;
    end
`ifdef PIPE_CTRL_STAT_EN
    if (m_stall_prev != 6'd0 && m_stat != 32'hFFFF_FFFF) m_stat = m_stat + 32'd1;
`endif
    if (m_flushing) begin
      m_flushing = 1'b0;
    end else if (m_dividing) begin
      if (excp_flush) begin
        m_dividing = 1'b0;
        m_flushing = 1'b1;
      end else if (div_done) begin
        m_dividing = 1'b0;
      end else if (m_elapsed + 1 == DIV_MAX) begin
        m_timeout  = 1'b1;
        m_dividing = 1'b0;
        m_flushing = 1'b1;
      end else begin
        m_elapsed = m_elapsed + 1;
      end
    end else if (excp_flush) begin
      m_flushing = 1'b1;
    end else if (div_start) begin
      m_dividing = 1'b1;
      m_elapsed  = 0;
    end
  endfunction

  function automatic logic [EXP_W-1:0] model_outputs();
    logic [5:0] s;
    s = 6'd0;
    if (rst) begin
      if (m_dividing)                      s = div_done ? 6'd0 : 6'b001111;
      else if (!m_flushing && stallreq_ex) s = 6'b001111;
      else if (!m_flushing && stallreq_id) s = 6'b000111;
    end
    m_stall_prev = s;
    return {s, m_flushing, m_dividing, m_flushing, m_timeout, m_stat};
  endfunction

  task automatic cyc(input logic r, input logic id, input logic ex,
                     input logic ds, input logic dd, input logic ef);
    @(posedge clk);
    model_step();
    #1;
    rst         = r;
    stallreq_id = id;
    stallreq_ex = ex;
    div_start   = ds;
    div_done    = dd;
    excp_flush  = ef;
    if (!rst) model_reset();
    exp_q.push_back(model_outputs());
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  initial begin
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] a;
    forever begin
      @(negedge clk);
      cycle_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {stall, flush, div_busy, div_cancel, div_timeout, stall_cycles};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL cycle%0d outputs: got stall=%b flush=%b busy=%b cancel=%b tmo=%b cnt=%0d, want stall=%b flush=%b busy=%b cancel=%b tmo=%b cnt=%0d",
                   cycle_no, a[41:36], a[35], a[34], a[33], a[32], a[31:0],
                   e[41:36], e[35], e[34], e[33], e[32], e[31:0]);
        end
      end
    end
  end

  initial begin
    int unsigned p_done;
    // Reset with requests asserted must still show a quiet pipeline
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_n(2);

    // ID hazard, then EX hazard on top, then clear
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Divide finishing after five wait cycles
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_n(5);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_n(2);

    // Divide that never completes: timeout, one flush cycle, sticky flag
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_n(DIV_MAX + 6);
    // div_start while waiting is ignored; exception and done together flush
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle_n(2);

    // Exception and divide start together in IDLE
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_n(2);

    // Reset mid-divide, then a normal divide afterwards
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_n(3);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_n(2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Seven stalled cycles for the statistics counter
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_n(2);

    // Random traffic; some phases suppress div_done so timeouts occur
    for (int ph = 0; ph < 8; ph++) begin
      p_done = (ph % 3 == 2) ? 0 : 8;
      for (int i = 0; i < 400; i++) begin
        cyc(($urandom_range(0, 499) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0),
            (p_done != 0) && ($urandom_range(0, p_done - 1) == 0),
            ($urandom_range(0, 63) == 0));
      end
    end
    idle_n(2);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
